clint: RTL
==========

# clint

Core-local interruptor that generates the machine timer and software interrupt lines consumed by the CSR file (`trint`, `swint`). It holds the memory-mapped `msip`, `mtimecmp` and free-running `mtime` registers, answers single-beat MMIO reads and writes from the data-bus arbiter, and drives registered interrupt levels into the core. It sits beside the core on the uncached MMIO path.

## Interface
- `PRESCALE`, default 1: core cycles per `mtime` increment (≥1).
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high with `req_valid`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte offset within the CLINT window.
- `req_wdata` in 64: write data.
- `req_strobe` in 8: byte enables for writes.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed.
- `resp_rdata` out 64: read data (0 for writes).
- `resp_err` out 1: unmapped or misaligned access.
- `trint` out 1: machine timer interrupt pending.
- `swint` out 1: machine software interrupt pending.
- `mtime_out` out 64: current `mtime`.

## Operation
- Register map, 8-byte aligned:
  - `0x0000` `msip`: only bit 0 is stored; other bits read 0.
  - `0x4000` `mtimecmp`.
  - `0xBFF8` `mtime`.
- Any other offset, or `req_addr[2:0] != 0`, gives `resp_err = 1`, read data 0, and no register change.
- FSM has two states.
  - IDLE: `req_ready = 1`, `resp_valid = 0`. When `req_valid` is high, the request is accepted at the edge, any write commits at that same edge, read data is latched into `resp_rdata`, and the FSM moves to RESP.
  - RESP: `req_ready = 0`, `resp_valid = 1`, and `resp_rdata`/`resp_err` are held stable. When `resp_ready` is high, the FSM returns to IDLE at the edge. There is no back-to-back acceptance, so throughput is at most one request per 2 cycles.
- Writes: each byte `i` of the target register updates only when `req_strobe[i]` is set. A `msip` write takes bit 0 only when `req_strobe[0]` is set.
- Read of `mtime` returns its value in the accept cycle, before that edge's increment.
- Prescaler:
  - The counter counts 0..`PRESCALE-1`. `mtime` increments by 1 on the cycle the counter equals `PRESCALE-1`, and the counter wraps to 0.
  - With `PRESCALE = 1`, `mtime` increments every cycle.
  - `mtime` wraps from 2^64−1 to 0.
- A write to `mtime` in the same cycle as an increment: the written bytes win, unwritten bytes take the incremented value, and the prescaler clears to 0.
- `trint` is registered as the unsigned compare `mtime >= mtimecmp`, evaluated on the current register values.
- `swint` is registered from `msip[0]`.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 2^64−1, `msip` = 0, prescaler = 0, FSM in IDLE.
  - `trint` = 0, `swint` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `req_ready` = 1 after reset releases.
- Reset asserted during RESP drops the pending response; the requester must not expect it.

## Timing
- Request accepted at edge N: write effect and read-data latch occur at edge N, and `resp_valid` is high from cycle N+1.
- `mtimecmp` or `msip` written at edge N: `trint`/`swint` reflect the new value after edge N+1 (one registered stage).
- `mtime` reaches `mtimecmp` at edge N: `trint` rises after edge N+1.
- `mtime_out` is the register itself, with zero latency.
- `req_ready` is a combinational function of the FSM state only, never of `req_valid`.

## Configuration
- `CLINT_MTIME_WRITE_EN` defined: `mtime` is writable per the strobe rules above.
- Not defined:
  - Writes to `0xBFF8` complete with `resp_err = 0` but leave `mtime` and the prescaler unchanged.
  - Reads are unaffected.

## Test plan
- Reset, then read `0x4000`, `0xBFF8` (after 5 idle cycles, `PRESCALE = 1`) and `0x0000` → `0xFFFF_FFFF_FFFF_FFFF`, value ≥ 5, and 0; `trint = swint = 0`.
- Write `msip = 0x1` with strobe `0x01` → `swint` high 2 cycles after accept. Write 0 → `swint` falls 2 cycles later.
- Write `mtimecmp = 20` with `PRESCALE = 1` → `trint` rises 1 cycle after `mtime` reaches 20. Write `mtimecmp = 0xFFFF_FFFF_FFFF_FFFF` → `trint` clears 2 cycles after accept.
- `PRESCALE = 4`, 16 cycles after reset → `mtime = 4`. With `CLINT_MTIME_WRITE_EN`, write `mtime = 100` on an increment cycle → 100, next increment 4 cycles later. Without the macro, the same write → `mtime` unchanged, `resp_err = 0`.
- Read `0x0008` and read `0x4004` → `resp_err = 1`, `resp_rdata = 0`, no register change. Hold `resp_ready = 0` for 3 cycles → response stable, `req_ready = 0` throughout.
- Partial write `mtimecmp` strobe `0x0F`, data `0x1234_5678` over value `0xFFFF_FFFF_FFFF_FFFF` → reads `0xFFFF_FFFF_1234_5678`. Assert `reset` in RESP → `resp_valid = 0` next cycle and all registers at reset values.

Source files
------------

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and prescaled mtime registers behind a single-beat MMIO port.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; otherwise mtime writes are accepted and ignored.
module clint #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strobe,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        trint,
  output logic        swint,
  output logic [63:0] mtime_out
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [15:0] AddrMsip     = 16'h0000;
  localparam logic [15:0] AddrMtimecmp = 16'h4000;
  localparam logic [15:0] AddrMtime    = 16'hBFF8;

  typedef enum logic {StIdle, StResp} state_e;

  state_e        state_q, state_d;
  logic          msip_q, msip_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          trint_q, trint_d;
  logic          swint_q, swint_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          tick;
  logic          accept;
  logic          hit_msip, hit_cmp, hit_time, hit_any;
  logic [63:0]   rd_val;

  always_comb begin
    state_d      = state_q;
    msip_d       = msip_q;
    mtimecmp_d   = mtimecmp_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = mtime_q + {63'd0, tick};

    // Interrupt levels look at the current registers, adding one stage of latency.
    trint_d = (mtime_q >= mtimecmp_q);
    swint_d = msip_q;

    hit_msip = (req_addr == AddrMsip);
    hit_cmp  = (req_addr == AddrMtimecmp);
    hit_time = (req_addr == AddrMtime);
    hit_any  = hit_msip | hit_cmp | hit_time;

    rd_val = 64'd0;
    if (hit_msip)      rd_val = {63'd0, msip_q};
    else if (hit_cmp)  rd_val = mtimecmp_q;
    else if (hit_time) rd_val = mtime_q;

    accept = (state_q == StIdle) && req_valid;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StResp;
          resp_err_d   = ~hit_any;
          resp_rdata_d = req_write ? 64'd0 : rd_val;
          if (req_write) begin
            if (hit_msip && req_strobe[0]) msip_d = req_wdata[0];
            if (hit_cmp) begin
              for (int i = 0; i < 8; i++) begin
                if (req_strobe[i]) mtimecmp_d[8*i +: 8] = req_wdata[8*i +: 8];
              end
            end
`ifdef CLINT_MTIME_WRITE_EN
            // Written bytes override the incremented value; the prescaler restarts.
            if (hit_time) begin
              for (int i = 0; i < 8; i++) begin
                if (req_strobe[i]) mtime_d[8*i +: 8] = req_wdata[8*i +: 8];
              end
              presc_d = '0;
            end
`endif
          end
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      msip_q       <= 1'b0;
      mtimecmp_q   <= '1;
      mtime_q      <= '0;
      presc_q      <= '0;
      trint_q      <= 1'b0;
      swint_q      <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      msip_q       <= msip_d;
      mtimecmp_q   <= mtimecmp_d;
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      trint_q      <= trint_d;
      swint_q      <= swint_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign trint      = trint_q;
  assign swint      = swint_q;
  assign mtime_out  = mtime_q;

endmodule
